// File: rtl/dcache_req_tracker.sv
// dcache_req_tracker: in-order retire tracker for CPU load/store/AMO traffic
// toward the data cache. Requests are allocated at tail, issued from the issue
// pointer, accept out-of-order responses by id and retire strictly from head.
// A kill flushes not-yet-issued entries and silently drains in-flight ones.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_*                     CPU request (valid/ready, op, addr, wdata, size, kill)
//   mem_req_*                 dcache request (valid/ready, op, addr, wdata, size, id)
//   mem_resp_*                dcache response (valid, id, data, err)
//   cpu_resp_*                CPU response (single-cycle valid, op, addr, data, err)
//   busy_o, count_o           occupancy status
//
// Optional feature: define DCACHE_TRACKER_RAW_STALL_EN to hold a load while an
// older in-flight store to the same 8-byte word has not completed.

module dcache_req_tracker #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  localparam int unsigned ID_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_kill_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [1:0]        mem_req_op_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [1:0]        mem_req_size_o,
  output logic [ID_W-1:0]   mem_req_id_o,
  input  logic              mem_resp_valid_i,
  input  logic [ID_W-1:0]   mem_resp_id_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  input  logic              mem_resp_err_i,
  output logic              cpu_resp_valid_o,
  output logic [1:0]        cpu_resp_op_o,
  output logic [ADDR_W-1:0] cpu_resp_addr_o,
  output logic [DATA_W-1:0] cpu_resp_data_o,
  output logic              cpu_resp_err_o,
  output logic              busy_o,
  output logic [ID_W:0]     count_o
);

  localparam int unsigned CNT_W = ID_W + 1;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_ISSUED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_AMO   = 2'd3;

  // Entry bookkeeping (reset) and payload (not reset)
  logic [1:0]        r_state [DEPTH];
  logic              r_drain [DEPTH];
  logic [1:0]        r_op    [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];
  logic [1:0]        r_size  [DEPTH];
  logic [DATA_W-1:0] r_rdata [DEPTH];
  logic              r_err   [DEPTH];

  logic [ID_W-1:0]   r_head;
  logic [ID_W-1:0]   r_issue;
  logic [ID_W-1:0]   r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_alloc;
  logic              w_amo_block;
  logic              w_raw_block;
  logic              w_mem_valid;
  logic              w_issue_fire;
  logic              w_resp_hit;
  logic              w_retire;
  logic [CNT_W-1:0]  w_n_pend;
  logic [CNT_W-1:0]  w_count_nxt;

  // Handshake and pointer-advance conditions
  assign req_ready_o  = (r_count < CNT_W'(DEPTH)) & ~req_kill_i;
  assign w_alloc      = req_valid_i & req_ready_o & (req_op_i != OP_NOP);
  // An AMO must be the oldest live entry before it may go out
  assign w_amo_block  = (r_op[r_issue] == OP_AMO) && (r_issue != r_head);
  assign w_mem_valid  = (r_state[r_issue] == ST_PEND) & ~w_amo_block & ~w_raw_block;
  assign w_issue_fire = w_mem_valid & mem_req_ready_i;
  assign w_resp_hit   = mem_resp_valid_i && (r_state[mem_resp_id_i] == ST_ISSUED);
  assign w_retire     = (r_state[r_head] == ST_DONE);

`ifdef DCACHE_TRACKER_RAW_STALL_EN
  // Only entries before the issue pointer can be ISSUED, so every ISSUED store is older
  always_comb begin
    w_raw_block = 1'b0;
    if (r_op[r_issue] == OP_LOAD) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((r_state[i] == ST_ISSUED) && !r_drain[i] && (r_op[i] == OP_STORE) &&
            (r_addr[i][ADDR_W-1:3] == r_addr[r_issue][ADDR_W-1:3])) begin
          w_raw_block = 1'b1;
        end
      end
    end
  end
`else
  assign w_raw_block = 1'b0;
`endif

  // Occupancy update; a kill drops every PEND entry except one issuing this cycle
  always_comb begin
    w_n_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_n_pend = w_n_pend + CNT_W'(r_state[i] == ST_PEND);
    end
    w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_retire);
    if (req_kill_i) begin
      w_count_nxt = w_count_nxt - w_n_pend + CNT_W'(w_issue_fire);
    end
  end

  // Entry state, drain flags, pointers and count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_issue <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_drain[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_retire && (ID_W'(i) == r_head)) begin
          r_state[i] <= ST_FREE;
          r_drain[i] <= 1'b0;
        end else if (w_resp_hit && (ID_W'(i) == mem_resp_id_i)) begin
          r_state[i] <= ST_DONE;
          if (req_kill_i) r_drain[i] <= 1'b1;
        end else if (w_issue_fire && (ID_W'(i) == r_issue)) begin
          r_state[i] <= ST_ISSUED;
          if (req_kill_i) r_drain[i] <= 1'b1;
        end else if (req_kill_i) begin
          if (r_state[i] == ST_PEND) r_state[i] <= ST_FREE;
          else if (r_state[i] != ST_FREE) r_drain[i] <= 1'b1;
        end else if (w_alloc && (ID_W'(i) == r_tail)) begin
          r_state[i] <= ST_PEND;
          r_drain[i] <= 1'b0;
        end
      end
      if (w_retire)     r_head  <= r_head + 1'b1;
      if (w_issue_fire) r_issue <= r_issue + 1'b1;
      if (req_kill_i)   r_tail  <= r_issue + ID_W'(w_issue_fire);
      else if (w_alloc) r_tail  <= r_tail + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Request payload at allocation, response payload on a valid response
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_op[r_tail]    <= req_op_i;
      r_addr[r_tail]  <= req_addr_i;
      r_wdata[r_tail] <= req_wdata_i;
      r_size[r_tail]  <= req_size_i;
    end
    if (w_resp_hit) begin
      r_rdata[mem_resp_id_i] <= mem_resp_data_i;
      r_err[mem_resp_id_i]   <= mem_resp_err_i;
    end
  end

  // Outputs are zeroed whenever their valid is low
  assign mem_req_valid_o  = w_mem_valid;
  assign mem_req_op_o     = w_mem_valid ? r_op[r_issue]    : '0;
  assign mem_req_addr_o   = w_mem_valid ? r_addr[r_issue]  : '0;
  assign mem_req_wdata_o  = w_mem_valid ? r_wdata[r_issue] : '0;
  assign mem_req_size_o   = w_mem_valid ? r_size[r_issue]  : '0;
  assign mem_req_id_o     = w_mem_valid ? r_issue          : '0;

  assign cpu_resp_valid_o = w_retire & ~r_drain[r_head];
  assign cpu_resp_op_o    = cpu_resp_valid_o ? r_op[r_head]    : '0;
  assign cpu_resp_addr_o  = cpu_resp_valid_o ? r_addr[r_head]  : '0;
  assign cpu_resp_data_o  = cpu_resp_valid_o ? r_rdata[r_head] : '0;
  assign cpu_resp_err_o   = cpu_resp_valid_o ? r_err[r_head]   : 1'b0;

  assign busy_o  = (r_count != '0);
  assign count_o = r_count;

endmodule

// File: tb/tb_dcache_req_tracker.sv
// tb_dcache_req_tracker: directed self-checking bench for dcache_req_tracker
// (DEPTH=4, 64-bit data/addr). Inputs change just after the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.

module tb_dcache_req_tracker;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_AMO   = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_kill_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [1:0]  mem_req_op_o;
  logic [63:0] mem_req_addr_o;
  logic [63:0] mem_req_wdata_o;
  logic [1:0]  mem_req_size_o;
  logic [1:0]  mem_req_id_o;
  logic        mem_resp_valid_i;
  logic [1:0]  mem_resp_id_i;
  logic [63:0] mem_resp_data_i;
  logic        mem_resp_err_i;
  logic        cpu_resp_valid_o;
  logic [1:0]  cpu_resp_op_o;
  logic [63:0] cpu_resp_addr_o;
  logic [63:0] cpu_resp_data_o;
  logic        cpu_resp_err_o;
  logic        busy_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  dcache_req_tracker #(.DEPTH(4), .DATA_W(64), .ADDR_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_kill_i(req_kill_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_op_o(mem_req_op_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_size_o(mem_req_size_o),
    .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
    .cpu_resp_valid_o(cpu_resp_valid_o), .cpu_resp_op_o(cpu_resp_op_o),
    .cpu_resp_addr_o(cpu_resp_addr_o), .cpu_resp_data_o(cpu_resp_data_o),
    .cpu_resp_err_o(cpu_resp_err_o), .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    req_valid_i = 1'b0; req_op_i = 2'd0; req_addr_i = '0; req_wdata_i = '0;
    req_size_i = 2'd3; req_kill_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0; mem_resp_id_i = '0; mem_resp_data_i = '0; mem_resp_err_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); idle(); rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i); idle(); #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", req_ready_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %0b exp 0", mem_req_valid_o); end
    checks++; if (cpu_resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_cpu_valid got %0b exp 0", cpu_resp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count_o); end
    checks++; if (mem_req_addr_o !== 64'd0 || cpu_resp_addr_o !== 64'd0 || cpu_resp_data_o !== 64'd0)
      begin errors++; $display("FAIL rst_data got %0h/%0h/%0h exp 0/0/0", mem_req_addr_o, cpu_resp_addr_o, cpu_resp_data_o); end
  endtask

  // Four loads, responses returned 3,2,1,0; CPU sees them 0,1,2,3
  task automatic test_ooo_resp();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i); idle();
      mem_req_ready_i = 1'b1;
      if (k < 4) begin req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h100 + 64'(8 * k); end
      #1;
      if (k > 0) begin
        checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'(k - 1))
          begin errors++; $display("FAIL ooo_issue%0d got v=%0b id=%0d exp v=1 id=%0d", k, mem_req_valid_o, mem_req_id_o, k - 1); end
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_i); idle();
      mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'(3 - j); mem_resp_data_i = 64'hCAFE_0000_0000_0000 | 64'(3 - j);
      #1;
      if (j == 0) begin
        checks++; if (count_o !== 3'd4 || req_ready_o !== 1'b0)
          begin errors++; $display("FAIL ooo_full got cnt=%0d rdy=%0b exp cnt=4 rdy=0", count_o, req_ready_o); end
      end
      checks++; if (cpu_resp_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_early_resp%0d got %0b exp 0", j, cpu_resp_valid_o); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); idle(); #1;
      checks++; if (cpu_resp_valid_o !== 1'b1 || cpu_resp_data_o !== (64'hCAFE_0000_0000_0000 | 64'(k)) ||
                    cpu_resp_addr_o !== 64'h100 + 64'(8 * k) || cpu_resp_op_o !== OP_LOAD)
        begin errors++; $display("FAIL ooo_retire%0d got v=%0b d=%0h a=%0h exp v=1 d=%0h a=%0h", k, cpu_resp_valid_o,
                                 cpu_resp_data_o, cpu_resp_addr_o, 64'hCAFE_0000_0000_0000 | 64'(k), 64'h100 + 64'(8 * k)); end
    end
    @(negedge clk_i); idle(); #1;
    checks++; if (busy_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL ooo_idle got busy=%0b cnt=%0d exp 0 0", busy_o, count_o); end
  endtask

  // Fill the tracker, reject a fifth request, reopen after one retire
  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); idle();
      req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h300 + 64'(8 * k);
    end
    @(negedge clk_i); idle();
    req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h500; #1;
    checks++; if (req_ready_o !== 1'b0 || count_o !== 3'd4) begin errors++; $display("FAIL full_ready got rdy=%0b cnt=%0d exp 0 4", req_ready_o, count_o); end
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd0 || mem_req_addr_o !== 64'h300)
      begin errors++; $display("FAIL full_hold got v=%0b id=%0d a=%0h exp 1 0 300", mem_req_valid_o, mem_req_id_o, mem_req_addr_o); end
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1; #1;
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_fifth got cnt=%0d exp 4", count_o); end
    @(negedge clk_i); idle(); mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0; mem_resp_data_i = 64'h77;
    @(negedge clk_i); idle(); #1;
    checks++; if (cpu_resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || cpu_resp_data_o !== 64'h77)
      begin errors++; $display("FAIL full_retire got v=%0b rdy=%0b d=%0h exp 1 0 77", cpu_resp_valid_o, req_ready_o, cpu_resp_data_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (req_ready_o !== 1'b1 || count_o !== 3'd3) begin errors++; $display("FAIL full_reopen got rdy=%0b cnt=%0d exp 1 3", req_ready_o, count_o); end
  endtask

  // AMO waits until the older load has retired
  task automatic test_amo();
    do_reset();
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h200;
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = OP_AMO; req_addr_i = 64'h208; req_wdata_i = 64'h55; #1;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd0) begin errors++; $display("FAIL amo_load_issue got v=%0b id=%0d exp 1 0", mem_req_valid_o, mem_req_id_o); end
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
      if (c == 6) begin mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0; mem_resp_data_i = 64'h1234; end
      #1;
      checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL amo_held_c%0d got %0b exp 0", c, mem_req_valid_o); end
      if (c == 7) begin
        checks++; if (cpu_resp_valid_o !== 1'b1 || cpu_resp_data_o !== 64'h1234)
          begin errors++; $display("FAIL amo_load_retire got v=%0b d=%0h exp 1 1234", cpu_resp_valid_o, cpu_resp_data_o); end
      end
    end
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1; #1;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd1 || mem_req_op_o !== OP_AMO ||
                  mem_req_addr_o !== 64'h208 || mem_req_wdata_o !== 64'h55)
      begin errors++; $display("FAIL amo_issue got v=%0b id=%0d op=%0d a=%0h w=%0h exp 1 1 3 208 55", mem_req_valid_o,
                               mem_req_id_o, mem_req_op_o, mem_req_addr_o, mem_req_wdata_o); end
    @(negedge clk_i); idle(); mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd1; mem_resp_data_i = 64'h99; mem_resp_err_i = 1'b1;
    @(negedge clk_i); idle(); #1;
    checks++; if (cpu_resp_valid_o !== 1'b1 || cpu_resp_op_o !== OP_AMO || cpu_resp_err_o !== 1'b1 || cpu_resp_data_o !== 64'h99)
      begin errors++; $display("FAIL amo_resp got v=%0b op=%0d e=%0b d=%0h exp 1 3 1 99", cpu_resp_valid_o, cpu_resp_op_o, cpu_resp_err_o, cpu_resp_data_o); end
  endtask

  // Kill with two issued and two pending: pending dropped, issued drained silently
  task automatic test_kill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); idle();
      mem_req_ready_i = (k == 1 || k == 2);
      req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h400 + 64'(8 * k);
    end
    @(negedge clk_i); idle(); req_kill_i = 1'b1; #1;
    checks++; if (count_o !== 3'd4 || req_ready_o !== 1'b0) begin errors++; $display("FAIL kill_pre got cnt=%0d rdy=%0b exp 4 0", count_o, req_ready_o); end
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk_i); idle();
      if (c == 5) begin mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd1; end
      if (c == 6) begin mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0; end
      #1;
      if (c == 5) begin
        checks++; if (count_o !== 3'd2 || mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL kill_post got cnt=%0d v=%0b exp 2 0", count_o, mem_req_valid_o); end
      end
      checks++; if (cpu_resp_valid_o !== 1'b0) begin errors++; $display("FAIL kill_silent_c%0d got %0b exp 0", c, cpu_resp_valid_o); end
    end
    checks++; if (count_o !== 3'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL kill_drained got cnt=%0d busy=%0b exp 0 0", count_o, busy_o); end
  endtask

  // Handshake completing in the kill cycle becomes a drained in-flight entry
  task automatic test_kill_issue();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i); idle(); req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h600 + 64'(8 * k);
    end
    @(negedge clk_i); idle(); req_kill_i = 1'b1; mem_req_ready_i = 1'b1; #1;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd0) begin errors++; $display("FAIL killiss_fire got v=%0b id=%0d exp 1 0", mem_req_valid_o, mem_req_id_o); end
    @(negedge clk_i); idle(); mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0; #1;
    checks++; if (count_o !== 3'd1 || mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL killiss_cnt got cnt=%0d v=%0b exp 1 0", count_o, mem_req_valid_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (cpu_resp_valid_o !== 1'b0) begin errors++; $display("FAIL killiss_silent got %0b exp 0", cpu_resp_valid_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL killiss_empty got cnt=%0d exp 0", count_o); end
  endtask

  // Store 0x1000 followed by load 0x1004 (same 8-byte word)
  task automatic test_raw();
    do_reset();
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = OP_STORE; req_addr_i = 64'h1000; req_wdata_i = 64'hAA;
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h1004; #1;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_op_o !== OP_STORE || mem_req_wdata_o !== 64'hAA)
      begin errors++; $display("FAIL raw_store got v=%0b op=%0d w=%0h exp 1 2 aa", mem_req_valid_o, mem_req_op_o, mem_req_wdata_o); end
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1; #1;
`ifdef DCACHE_TRACKER_RAW_STALL_EN
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall got %0b exp 0", mem_req_valid_o); end
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0; #1;
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall2 got %0b exp 0", mem_req_valid_o); end
    @(negedge clk_i); idle(); mem_req_ready_i = 1'b1; #1;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd1 || mem_req_addr_o !== 64'h1004)
      begin errors++; $display("FAIL raw_release got v=%0b id=%0d a=%0h exp 1 1 1004", mem_req_valid_o, mem_req_id_o, mem_req_addr_o); end
`else
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_id_o !== 2'd1 || mem_req_op_o !== OP_LOAD || mem_req_addr_o !== 64'h1004)
      begin errors++; $display("FAIL raw_noStall got v=%0b id=%0d op=%0d a=%0h exp 1 1 1 1004", mem_req_valid_o, mem_req_id_o, mem_req_op_o, mem_req_addr_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL raw_after got %0b exp 0", mem_req_valid_o); end
`endif
  endtask

  // Reset with three in flight; a late response must be ignored
  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); idle(); mem_req_ready_i = 1'b1;
      if (k < 3) begin req_valid_i = 1'b1; req_op_i = OP_LOAD; req_addr_i = 64'h700 + 64'(8 * k); end
    end
    @(negedge clk_i); idle(); #1;
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre got cnt=%0d exp 3", count_o); end
    rst_i = 1'b1;
    @(negedge clk_i); idle(); rst_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd1; mem_resp_data_i = 64'hDEAD; #1;
    checks++; if (cpu_resp_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rmid_resp got v=%0b cnt=%0d exp 0 0", cpu_resp_valid_o, count_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (cpu_resp_valid_o !== 1'b0 || count_o !== 3'd0 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0)
      begin errors++; $display("FAIL rmid_after got v=%0b cnt=%0d busy=%0b mv=%0b exp 0 0 0 0", cpu_resp_valid_o, count_o, busy_o, mem_req_valid_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_ooo_resp();
    test_full();
    test_amo();
    test_kill();
    test_kill_issue();
    test_raw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_req_tracker.md
DCACHE_REQ_TRACKER -- requirements
Module: dcache_req_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning tracker entries (power of 2, at least 2).
REQ-002 SHALL have parameter DATA_W, default 64, meaning load/store data width.
REQ-003 SHALL have parameter ADDR_W, default 64, meaning address width; ID_W = log2(DEPTH).
REQ-004 SHALL have ports: clk_i in 1, clock; rst_i in 1, reset, synchronous, active-high.
REQ-005 SHALL have CPU ports: req_valid_i in 1; req_ready_o out 1; req_op_i in 2 (00 NOP, 01 LOAD, 10 STORE, 11 AMO); req_addr_i in ADDR_W; req_wdata_i in DATA_W; req_size_i in 2; req_kill_i in 1, flush.
REQ-006 SHALL have dcache request ports: mem_req_valid_o out 1; mem_req_ready_i in 1; mem_req_op_o out 2; mem_req_addr_o out ADDR_W; mem_req_wdata_o out DATA_W; mem_req_size_o out 2; mem_req_id_o out ID_W.
REQ-007 SHALL have dcache response ports: mem_resp_valid_i in 1; mem_resp_id_i in ID_W; mem_resp_data_i in DATA_W; mem_resp_err_i in 1.
REQ-008 SHALL have CPU response ports: cpu_resp_valid_o out 1; cpu_resp_op_o out 2; cpu_resp_addr_o out ADDR_W; cpu_resp_data_o out DATA_W; cpu_resp_err_o out 1; busy_o out 1; count_o out ID_W+1.

Function
REQ-009 SHALL hold a circular buffer with head (retire), issue and tail (allocate) pointers, all wrapping modulo DEPTH.
REQ-010 SHALL give each entry a state: FREE, PEND (allocated, not sent), ISSUED (sent, awaiting response), DONE (response received), each with a drain flag.
REQ-011 SHALL drive req_ready_o = (count_o < DEPTH) & !req_kill_i; the full check uses the pre-retire count.
REQ-012 SHALL allocate at tail on req_valid_i & req_ready_o & req_op_i != NOP, capturing op/addr/wdata/size; a NOP is accepted and dropped.
REQ-013 SHALL drive mem_req_valid_o combinationally when the issue-pointer entry is PEND; mem_req_id_o SHALL equal that entry index.
REQ-014 SHALL issue an AMO only when its entry is at head (all older entries retired); until then mem_req_valid_o stays low.
REQ-015 SHALL, on mem_req_valid_o & mem_req_ready_i, move the entry to ISSUED and advance the issue pointer; mem_req_* SHALL hold stable while valid and not ready.
REQ-016 SHALL, on mem_resp_valid_i, move entry mem_resp_id_i from ISSUED to DONE, capturing data and err; a response to a non-ISSUED entry SHALL be ignored.
REQ-017 SHALL accept responses in any order and retire strictly in order.
REQ-018 SHALL assert cpu_resp_valid_o for one cycle when the head is DONE without drain, presenting the entry's op/addr/data/err, and free it the same cycle with no backpressure.
REQ-019 SHALL free a head entry that is DONE with drain silently, with cpu_resp_valid_o low.
REQ-020 SHALL, on req_kill_i: free all PEND entries by setting tail to issue; set drain on all ISSUED and DONE entries; perform no allocation that cycle.
REQ-021 SHALL treat an entry whose request handshake completes in the kill cycle as ISSUED+drain.
REQ-022 SHALL let a response arriving in the kill cycle complete as DONE+drain.
REQ-023 SHALL allow allocate, issue, response and retire in the same cycle; count_o SHALL equal allocations minus retirements.
REQ-024 SHALL drive busy_o = (count_o != 0).

Reset
REQ-025 SHALL, while rst_i is high at a clock edge, set all pointers to 0, all entries FREE with drain clear, and count_o to 0.
REQ-026 SHALL, after reset, hold these output values: req_ready_o=1, mem_req_valid_o=0, cpu_resp_valid_o=0, busy_o=0, and all data/addr outputs=0.
REQ-027 SHALL discard outstanding dcache transactions on reset mid-operation; later responses are ignored by REQ-016.

Configuration
REQ-028 SHALL, with DCACHE_TRACKER_RAW_STALL_EN defined, hold a PEND load at the issue pointer while any older non-FREE, non-drain STORE has the same addr[ADDR_W-1:3] and is not DONE.
REQ-029 SHALL, with DCACHE_TRACKER_RAW_STALL_EN undefined, issue loads in order with no address comparison.

Verification
REQ-030 SHALL be verified by: DEPTH=4, 4 LOADs, mem_req_ready_i=1, responses in id order 3,2,1,0 -> cpu_resp in order 0,1,2,3 with matching data; busy_o=0 after.
REQ-031 SHALL be verified by: 4 allocations with no responses -> req_ready_o=0, count_o=4; a fifth request is not accepted; after one retire, req_ready_o=1.
REQ-032 SHALL be verified by: LOAD, then AMO with the load response delayed 5 cycles -> AMO mem_req_valid_o stays low until the cycle after the LOAD retires.
REQ-033 SHALL be verified by: 2 ISSUED plus 2 PEND, then req_kill_i -> count_o=2; both responses accepted; cpu_resp_valid_o never asserts; count_o=0.
REQ-034 SHALL be verified by: with the macro defined, STORE 0x1000 then LOAD 0x1004 -> LOAD not issued until STORE DONE; without the macro, LOAD issues the cycle after the STORE.
REQ-035 SHALL be verified by: rst_i asserted with 3 entries outstanding, then mem_resp_valid_i id=1 -> no state change; cpu_resp_valid_o=0; count_o=0.
